pc_sequencer: RTL and testbench

Owns the program-counter register for the fetch stage and decides the next PC every cycle. It arbitrates four redirect sources in strict priority: EX-stage misprediction correction, fetch-stage predicted-taken branch, jump, and sequential +4. It contains a direct-mapped 2-bit branch history table (BHT) that makes the fetch-stage prediction and is trained by resolved EX branches. It emits the prediction bit that travels down the pipeline and the flush pulse for the front-end registers.

---
 rtl/pc_seq_pkg.sv | 33 +++
 rtl/bht_2bit.sv | 55 +++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and helpers for the fetch-stage PC sequencer and its branch
// history table.
//   bht_ctr_t  : 2-bit saturating branch counter
//   SNT..ST    : counter encodings; the MSB is the taken prediction
//   PC_STEP    : sequential fetch increment in bytes
//   sat_update : one training step of a 2-bit counter
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    localparam int unsigned PC_STEP = 4;

    // Move one step toward taken/not-taken, sticking at either end.
    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
// Direct-mapped table of 2-bit saturating branch counters.
//   clk          : system clock, rising edge
//   i_rst_n      : synchronous active-low reset, all counters to WNT
//   i_rd_idx     : read index (combinational read)
//   o_rd_ctr     : counter at i_rd_idx, value before any same-cycle update
//   i_upd_en     : train the counter at i_upd_idx this cycle
//   i_upd_idx    : update index
//   i_upd_taken  : resolved outcome used for training
// Counters are individual registers rather than RAM: every entry needs a
// reset value and the read must be same-cycle.
// ---------------------------------------------------------------------------
module bht_2bit
    import pc_seq_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_t         o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    bht_ctr_t w_ctr_all [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            bht_ctr_t r_ctr;
            logic     w_hit;

            assign w_hit = i_upd_en && (i_upd_idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (!i_rst_n) begin
                    r_ctr <= WNT;
                end else if (w_hit) begin
                    r_ctr <= sat_update(r_ctr, i_upd_taken);
                end
            end

            assign w_ctr_all[gi] = r_ctr;
        end
    endgenerate

    // Reads see the registered value, so a same-cycle update is not
    // visible until the following cycle.
    assign o_rd_ctr = w_ctr_all[i_rd_idx];

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program counter with next-PC arbitration and a 2-bit BHT.
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_i             : hold PC (overridden by an EX mispredict)
//   jump_en_i/target    : unconditional jump redirect
//   branch_F_i/target   : conditional branch at pc_o and its taken target
//   ex_valid_i, ex_taken_i, ex_pred_i, ex_pc_i, ex_target_i
//                       : branch resolved in EX, used for correction and
//                         BHT training
//   pc_o                : registered fetch PC
//   pred_taken_o        : BHT prediction for pc_o, gated by branch_F_i
//   flush_o             : one-cycle pulse after each mispredict cycle
//   mispredict_cnt_o    : saturating mispredict counter
// Redirect priority: mispredict > stall > predicted-taken > jump > +4.
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               BHT_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             jump_en_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_F_i,
    input  logic [WIDTH-1:0] branch_target_F_i,
    input  logic             ex_valid_i,
    input  logic             ex_taken_i,
    input  logic             ex_pred_i,
    input  logic [WIDTH-1:0] ex_pc_i,
    input  logic [WIDTH-1:0] ex_target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pred_taken_o,
    output logic             flush_o,
    output logic [15:0]      mispredict_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [WIDTH-1:0] r_pc;
    logic             r_flush;
    logic [15:0]      r_mis_cnt;

    logic [WIDTH-1:0] w_pc_next;
    logic             w_mis;
    logic             w_pred;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    bht_ctr_t         w_rd_ctr;

    // Word-aligned index: the two byte-offset bits never select an entry.
    assign w_rd_idx  = r_pc[IDX_W+1:2];
    assign w_upd_idx = ex_pc_i[IDX_W+1:2];

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_rd_idx    (w_rd_idx),
        .o_rd_ctr    (w_rd_ctr),
        .i_upd_en    (ex_valid_i),
        .i_upd_idx   (w_upd_idx),
        .i_upd_taken (ex_taken_i)
    );

    assign w_mis  = ex_valid_i && (ex_taken_i != ex_pred_i);
    assign w_pred = branch_F_i && w_rd_ctr[1];

    always_comb begin
        w_pc_next = r_pc + WIDTH'(PC_STEP);
        if (w_mis) begin
            // Correction wins even over stall: the stalled fetch is on the
            // wrong path anyway and is flushed.
            w_pc_next = ex_taken_i ? ex_target_i : (ex_pc_i + WIDTH'(PC_STEP));
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (w_pred) begin
            w_pc_next = branch_target_F_i;
        end else if (jump_en_i) begin
            w_pc_next = jump_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_flush   <= 1'b0;
            r_mis_cnt <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_flush <= w_mis;
            if (w_mis && (r_mis_cnt != 16'hFFFF)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
        end
    end

    assign pc_o             = r_pc;
    assign pred_taken_o     = w_pred;
    assign flush_o          = r_flush;
    assign mispredict_cnt_o = r_mis_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed stimulus for pc_sequencer with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        jump_en_i;
    logic [31:0] jump_target_i;
    logic        branch_F_i;
    logic [31:0] branch_target_F_i;
    logic        ex_valid_i;
    logic        ex_taken_i;
    logic        ex_pred_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic        flush_o;
    logic [15:0] mispredict_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .WIDTH       (32),
        .BHT_ENTRIES (16),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .jump_en_i         (jump_en_i),
        .jump_target_i     (jump_target_i),
        .branch_F_i        (branch_F_i),
        .branch_target_F_i (branch_target_F_i),
        .ex_valid_i        (ex_valid_i),
        .ex_taken_i        (ex_taken_i),
        .ex_pred_i         (ex_pred_i),
        .ex_pc_i           (ex_pc_i),
        .ex_target_i       (ex_target_i),
        .pc_o              (pc_o),
        .pred_taken_o      (pred_taken_o),
        .flush_o           (flush_o),
        .mispredict_cnt_o  (mispredict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one edge; inputs are then driven and registered outputs
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_ex();
        ex_valid_i  = 1'b0;
        ex_taken_i  = 1'b0;
        ex_pred_i   = 1'b0;
        ex_pc_i     = 32'h0;
        ex_target_i = 32'h0;
    endtask

    task automatic set_ex(input logic taken, input logic pred,
                          input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid_i  = 1'b1;
        ex_taken_i  = taken;
        ex_pred_i   = pred;
        ex_pc_i     = pc;
        ex_target_i = tgt;
    endtask

    initial begin
        rst_n             = 1'b0;
        stall_i           = 1'b0;
        jump_en_i         = 1'b0;
        jump_target_i     = 32'h0;
        branch_F_i        = 1'b0;
        branch_target_F_i = 32'h0;
        clear_ex();

        // Reset state
        tick();
        tick();
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_flush", {31'b0, flush_o}, 32'h0);
        check_eq("rst_cnt", {16'b0, mispredict_cnt_o}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("rst_ctr%0d", i), {30'b0, dut.u_bht.w_ctr_all[i]}, 32'h1);
        end

        // Free-running sequential fetch
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq($sformatf("seq_pc%0d", k), pc_o, 32'(k * 4));
        end
        check_eq("seq_flush", {31'b0, flush_o}, 32'h0);

        // Branch at 0x10 resolved taken twice while predicted not-taken
        set_ex(1'b1, 1'b0, 32'h10, 32'h80);
        tick();
        check_eq("mis1_pc", pc_o, 32'h80);
        check_eq("mis1_flush", {31'b0, flush_o}, 32'h1);
        check_eq("mis1_cnt", {16'b0, mispredict_cnt_o}, 32'h1);
        check_eq("mis1_ctr4", {30'b0, dut.u_bht.w_ctr_all[4]}, 32'h2);
        tick();
        check_eq("mis2_pc", pc_o, 32'h80);
        check_eq("mis2_flush", {31'b0, flush_o}, 32'h1);
        check_eq("mis2_cnt", {16'b0, mispredict_cnt_o}, 32'h2);
        check_eq("mis2_ctr4", {30'b0, dut.u_bht.w_ctr_all[4]}, 32'h3);
        clear_ex();
        tick();
        check_eq("post_mis_flush", {31'b0, flush_o}, 32'h0);
        check_eq("post_mis_pc", pc_o, 32'h84);

        // Return to 0x10 via a jump, then predicted-taken beats jump
        jump_en_i     = 1'b1;
        jump_target_i = 32'h10;
        tick();
        check_eq("jmp_to_10", pc_o, 32'h10);
        branch_F_i        = 1'b1;
        branch_target_F_i = 32'h100;
        jump_target_i     = 32'h200;
        settle();
        check_eq("pred_at_10", {31'b0, pred_taken_o}, 32'h1);
        tick();
        check_eq("pred_beats_jump", pc_o, 32'h100);

        // Branch at 0x200 (idx 0, WNT): no prediction, jump wins
        branch_F_i    = 1'b0;
        jump_target_i = 32'h200;
        tick();
        check_eq("jmp_to_200", pc_o, 32'h200);
        branch_F_i        = 1'b1;
        branch_target_F_i = 32'h300;
        jump_target_i     = 32'h400;
        settle();
        check_eq("nopred_at_200", {31'b0, pred_taken_o}, 32'h0);
        tick();
        check_eq("jump_wins", pc_o, 32'h400);
        jump_en_i = 1'b0;

        // Read/update collision at idx 0 while stalled (correct prediction)
        stall_i = 1'b1;
        set_ex(1'b1, 1'b1, 32'h0, 32'h500);
        settle();
        check_eq("coll_pre", {31'b0, pred_taken_o}, 32'h0);
        tick();
        check_eq("coll_hold_pc", pc_o, 32'h400);
        check_eq("coll_noflush", {31'b0, flush_o}, 32'h0);
        clear_ex();
        settle();
        check_eq("coll_post", {31'b0, pred_taken_o}, 32'h1);
        branch_F_i = 1'b0;

        // Mispredict during stall: not-taken at 0x40 -> 0x44
        set_ex(1'b0, 1'b1, 32'h40, 32'h999);
        tick();
        check_eq("stall_mis_pc", pc_o, 32'h44);
        check_eq("stall_mis_flush", {31'b0, flush_o}, 32'h1);
        check_eq("stall_mis_cnt", {16'b0, mispredict_cnt_o}, 32'h3);
        check_eq("stall_mis_ctr0", {30'b0, dut.u_bht.w_ctr_all[0]}, 32'h1);
        clear_ex();
        tick();
        check_eq("stall_hold_pc", pc_o, 32'h44);
        check_eq("stall_flush_end", {31'b0, flush_o}, 32'h0);
        stall_i = 1'b0;

        // Wrap-around of +4
        jump_en_i     = 1'b1;
        jump_target_i = 32'hFFFF_FFFC;
        tick();
        check_eq("wrap_pre", pc_o, 32'hFFFF_FFFC);
        jump_en_i = 1'b0;
        tick();
        check_eq("wrap_post", pc_o, 32'h0);

        // Reset mid-stream with a mispredict asserted
        set_ex(1'b1, 1'b0, 32'h10, 32'h80);
        rst_n = 1'b0;
        tick();
        check_eq("mrst_pc", pc_o, 32'h0);
        check_eq("mrst_flush", {31'b0, flush_o}, 32'h0);
        check_eq("mrst_cnt", {16'b0, mispredict_cnt_o}, 32'h0);
        check_eq("mrst_ctr4", {30'b0, dut.u_bht.w_ctr_all[4]}, 32'h1);
        rst_n = 1'b1;

        // Saturate the mispredict counter (not-taken at 0x0 each cycle)
        set_ex(1'b0, 1'b1, 32'h0, 32'h0);
        for (int n = 0; n < 65534; n++) begin
            tick();
        end
        check_eq("sat_fffe", {16'b0, mispredict_cnt_o}, 32'h0000_FFFE);
        check_eq("sat_pc", pc_o, 32'h4);
        tick();
        check_eq("sat_ffff", {16'b0, mispredict_cnt_o}, 32'h0000_FFFF);
        tick();
        check_eq("sat_hold", {16'b0, mispredict_cnt_o}, 32'h0000_FFFF);
        check_eq("sat_flush", {31'b0, flush_o}, 32'h1);
        check_eq("sat_ctr0", {30'b0, dut.u_bht.w_ctr_all[0]}, 32'h0);
        clear_ex();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
